// File: rtl/fcvt_round_stage.sv
// ============================================================================
// Module   : fcvt_round_stage
// Purpose  : Round/pack stage for FCVT.S.W / FCVT.S.WU, two-stage valid/ready
//            pipeline. Optional flush port under `FCVT_ROUND_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fcvt_round_stage #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef FCVT_ROUND_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic             in_zero,
  input  logic [7:0]       in_exp,
  input  logic [31:0]      in_sig,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_fflags,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam logic [2:0] c_rm_rne = 3'b000;
  localparam logic [2:0] c_rm_rtz = 3'b001;
  localparam logic [2:0] c_rm_rdn = 3'b010;
  localparam logic [2:0] c_rm_rup = 3'b011;
  localparam logic [2:0] c_rm_rmm = 3'b100;

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [7:0]       r_s1_exp;
  logic [22:0]      r_s1_mant;
  logic             r_s1_inc;
  logic [4:0]       r_s1_flags;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [31:0]      r_s2_result;
  logic [4:0]       r_s2_flags;
  logic [TAG_W-1:0] r_s2_tag;

  logic             w_flush;
  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;
  logic [22:0]      w_mant;
  logic             w_g;
  logic             w_s;
  logic             w_inc;
  logic             w_illegal;
  logic             w_d_sign;
  logic [7:0]       w_d_exp;
  logic [22:0]      w_d_mant;
  logic             w_d_inc;
  logic [4:0]       w_d_flags;
  logic [23:0]      w_sum;
  logic [7:0]       w_exp_n;
  logic             w_unused;

`ifdef FCVT_ROUND_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv & ~w_flush;
  assign w_accept = in_valid & in_ready;

  // Bit 31 is the implicit leading one and never reaches the packed result.
  assign w_unused = in_sig[31];
  assign w_mant   = in_sig[30:8];
  assign w_g      = in_sig[7];
  assign w_s      = |in_sig[6:0];
  assign w_illegal = (in_rm > c_rm_rmm);

  always_comb begin
    w_inc = 1'b0;
    case (in_rm)
      c_rm_rne: w_inc = w_g & (w_s | w_mant[0]);
      c_rm_rtz: w_inc = 1'b0;
      c_rm_rdn: w_inc = in_sign & (w_g | w_s);
      c_rm_rup: w_inc = ~in_sign & (w_g | w_s);
      c_rm_rmm: w_inc = w_g;
      default:  w_inc = 1'b0;
    endcase
  end

  // Special results are encoded as ordinary fields with inc=0 so S2 packs them as-is.
  always_comb begin
    w_d_sign  = in_sign;
    w_d_exp   = in_exp;
    w_d_mant  = w_mant;
    w_d_inc   = w_inc;
    w_d_flags = {4'b0000, w_g | w_s};
    if (w_illegal) begin
      w_d_sign  = 1'b0;
      w_d_exp   = 8'hFF;
      w_d_mant  = 23'h400000;
      w_d_inc   = 1'b0;
      w_d_flags = 5'b10000;
    end else if (in_zero) begin
      w_d_sign  = 1'b0;
      w_d_exp   = 8'h00;
      w_d_mant  = 23'h000000;
      w_d_inc   = 1'b0;
      w_d_flags = 5'b00000;
    end
  end

  // A mantissa carry leaves sum[22:0] at zero, so only the exponent needs adjusting.
  assign w_sum   = {1'b0, r_s1_mant} + {23'h000000, r_s1_inc};
  assign w_exp_n = r_s1_exp + {7'h00, w_sum[23]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_exp    <= 8'h00;
      r_s1_mant   <= 23'h000000;
      r_s1_inc    <= 1'b0;
      r_s1_flags  <= 5'b00000;
      r_s1_tag    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= 32'h00000000;
      r_s2_flags  <= 5'b00000;
      r_s2_tag    <= '0;
    end else begin
      if (w_flush) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
      end else begin
        if (w_s1_adv) r_s1_valid <= in_valid;
        if (w_s2_adv) r_s2_valid <= r_s1_valid;
      end
      if (w_accept) begin
        r_s1_sign  <= w_d_sign;
        r_s1_exp   <= w_d_exp;
        r_s1_mant  <= w_d_mant;
        r_s1_inc   <= w_d_inc;
        r_s1_flags <= w_d_flags;
        r_s1_tag   <= in_tag;
      end
      if (w_s2_adv && r_s1_valid) begin
        r_s2_result <= {r_s1_sign, w_exp_n, w_sum[22:0]};
        r_s2_flags  <= r_s1_flags;
        r_s2_tag    <= r_s1_tag;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_fflags = r_s2_flags;
  assign out_tag    = r_s2_tag;
  assign busy       = r_s1_valid | r_s2_valid;

endmodule

`default_nettype wire

// File: tb/tb_fcvt_round_stage.sv
// ============================================================================
// Module   : tb_fcvt_round_stage
// Purpose  : Self-checking bench for fcvt_round_stage against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fcvt_round_stage;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sign = 1'b0;
  logic             in_zero = 1'b0;
  logic [7:0]       in_exp = 8'h00;
  logic [31:0]      in_sig = 32'h0;
  logic [2:0]       in_rm = 3'b000;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [4:0]       out_fflags;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
`ifdef FCVT_ROUND_FLUSH_EN
  logic             flush = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  logic [TAG_W+36:0] sb[$];

  fcvt_round_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef FCVT_ROUND_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_zero(in_zero),
    .in_exp(in_exp), .in_sig(in_sig), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_fflags(out_fflags), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: round the 24-bit truncated significand by comparing the dropped byte to one half.
  function automatic logic [36:0] model(input logic sign, input logic zero, input logic [7:0] exp,
                                        input logic [31:0] sig, input logic [2:0] rm);
    int unsigned trunc, rem, r, e;
    logic up;
    if (rm > 3'd4) return {5'b10000, 32'h7FC00000};
    if (zero) return 37'h0;
    trunc = sig >> 8;
    rem = sig & 32'hFF;
    e = exp;
    case (rm)
      3'd0: up = (rem > 128) || (rem == 128 && (trunc % 2) == 1);
      3'd1: up = 1'b0;
      3'd2: up = sign && (rem != 0);
      3'd3: up = !sign && (rem != 0);
      default: up = (rem >= 128);
    endcase
    r = trunc + (up ? 1 : 0);
    if (r == (32'd1 << 24)) begin
      r = r >> 1;
      e = e + 1;
    end
    return {4'b0000, rem != 0, sign, e[7:0], r[22:0]};
  endfunction

  task automatic gen_op(output logic sign, output logic zero, output logic [7:0] exp,
                        output logic [31:0] sig, output logic [2:0] rm);
    logic [31:0] x;
    int n;
    x = $urandom;
    if ($urandom % 16 == 0) x = 0;
    else if ($urandom % 8 == 0) x = 32'hFFFFFFFF;
    sign = $urandom % 2;
    zero = (x == 0);
    rm = ($urandom % 8 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    if (zero) begin
      exp = 8'h00;
      sig = 32'h0;
    end else begin
      n = 31;
      while (x[n] == 1'b0) n--;
      exp = 8'(127 + n);
      sig = x << (31 - n);
      case ($urandom % 6)
        0: sig[7:0] = 8'h80;
        1: sig[7:0] = 8'h00;
        2: sig[7:0] = 8'h7F;
        default: ;
      endcase
    end
  endtask

  // Presents one op to an empty pipeline; lat = posedges until out_valid, -1 on timeout.
  task automatic do_op(input logic sign, input logic zero, input logic [7:0] exp,
                       input logic [31:0] sig, input logic [2:0] rm, input logic [TAG_W-1:0] tag,
                       output logic [31:0] res, output logic [4:0] ff,
                       output logic [TAG_W-1:0] otag, output int lat);
    in_sign = sign; in_zero = zero; in_exp = exp; in_sig = sig; in_rm = rm; in_tag = tag;
    in_valid = 1'b1;
    out_ready = 1'b1;
    lat = -1;
    res = 32'h0; ff = 5'h0; otag = '0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = c;
        res = out_result;
        ff = out_fflags;
        otag = out_tag;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", out_result); end
    total++; if (out_fflags !== 5'h0) begin bad++; $display("FAIL reset_fflags: got %b want 0", out_fflags); end
    total++; if (out_tag !== '0) begin bad++; $display("FAIL reset_tag: got %0d want 0", out_tag); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_vectors();
    logic s, z; logic [7:0] e; logic [31:0] g; logic [2:0] m;
    logic [31:0] want_r, res; logic [4:0] want_f, ff; logic [TAG_W-1:0] otag; int lat;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin s=0; z=0; e=8'h97; g=32'h80000080; m=3'd0; want_r=32'h4B800000; want_f=5'h01; end
        1: begin s=0; z=0; e=8'h97; g=32'h80000080; m=3'd3; want_r=32'h4B800001; want_f=5'h01; end
        2: begin s=0; z=0; e=8'h9E; g=32'hFFFFFFFF; m=3'd0; want_r=32'h4F800000; want_f=5'h01; end
        3: begin s=0; z=0; e=8'h9E; g=32'hFFFFFFFF; m=3'd1; want_r=32'h4F7FFFFF; want_f=5'h01; end
        4: begin s=1; z=0; e=8'h7F; g=32'h80000000; m=3'd2; want_r=32'hBF800000; want_f=5'h00; end
        5: begin s=1; z=0; e=8'h97; g=32'h80000080; m=3'd2; want_r=32'hCB800001; want_f=5'h01; end
        6: begin s=1; z=1; e=8'h00; g=32'h0;        m=3'd4; want_r=32'h00000000; want_f=5'h00; end
        default: begin s=0; z=1; e=8'h00; g=32'h0; m=3'd5; want_r=32'h7FC00000; want_f=5'h10; end
      endcase
      do_op(s, z, e, g, m, TAG_W'(i + 1), res, ff, otag, lat);
      total++; if (lat != 2) begin bad++; $display("FAIL vec%0d_latency: got %0d want 2", i, lat); end
      total++; if (res !== want_r) begin bad++; $display("FAIL vec%0d_result: got %h want %h", i, res, want_r); end
      total++; if (ff !== want_f) begin bad++; $display("FAIL vec%0d_fflags: got %b want %b", i, ff, want_f); end
      total++; if (otag !== TAG_W'(i + 1)) begin bad++; $display("FAIL vec%0d_tag: got %0d want %0d", i, otag, i + 1); end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic s, z; logic [7:0] e; logic [31:0] g; logic [2:0] m;
    logic took, held;
    logic [TAG_W+36:0] held_val, exp_v, got;
    logic [TAG_W-1:0] tag;
    int guard;
    sb.delete();
    took = 1'b1; held = 1'b0; tag = '0; held_val = '0;
    s = 0; z = 0; e = 0; g = 0; m = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (held) begin
        got = {out_tag, out_fflags, out_result};
        total++; if (out_valid !== 1'b1 || got !== held_val) begin
          bad++; $display("FAIL rand_stall_stable: got v=%0b %h want v=1 %h", out_valid, got, held_val);
        end
      end
      if (took) begin
        gen_op(s, z, e, g, m);
        tag = tag + 1'b1;
        in_valid = ($urandom % 4 != 0);
      end
      in_sign = s; in_zero = z; in_exp = e; in_sig = g; in_rm = m; in_tag = tag;
      out_ready = ($urandom % 3 != 0);
      #1;
      if (out_valid && out_ready) begin
        got = {out_tag, out_fflags, out_result};
        exp_v = (sb.size() > 0) ? sb.pop_front() : '1;
        total++; if (got !== exp_v) begin bad++; $display("FAIL rand_result: got %h want %h", got, exp_v); end
      end
      if (in_valid && in_ready) sb.push_back({tag, model(s, z, e, g, m)});
      took = !in_valid || in_ready;
      held = out_valid && !out_ready;
      held_val = {out_tag, out_fflags, out_result};
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      #1;
      if (out_valid) begin
        got = {out_tag, out_fflags, out_result};
        exp_v = sb.pop_front();
        total++; if (got !== exp_v) begin bad++; $display("FAIL rand_drain: got %h want %h", got, exp_v); end
      end
      @(negedge clk);
      guard++;
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL rand_drain_timeout: got %0d pending want 0", sb.size()); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic s[4], z[4]; logic [7:0] e[4]; logic [31:0] g[4]; logic [2:0] m[4];
    logic [TAG_W+36:0] snap, got, exp_v;
    int idx, nout, first_c, last_c;
    sb.delete();
    for (int i = 0; i < 4; i++) gen_op(s[i], z[i], e[i], g[i], m[i]);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_sign = s[idx]; in_zero = z[idx]; in_exp = e[idx]; in_sig = g[idx]; in_rm = m[idx];
        in_tag = TAG_W'(10 + idx);
      end
      #1;
      if (in_valid && in_ready) begin
        sb.push_back({TAG_W'(10 + idx), model(s[idx], z[idx], e[idx], g[idx], m[idx])});
        idx++;
      end
      @(negedge clk);
    end
    total++; if (idx != 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", idx); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    snap = {out_tag, out_fflags, out_result};
    repeat (3) @(negedge clk);
    got = {out_tag, out_fflags, out_result};
    total++; if (out_valid !== 1'b1 || got !== snap || out_tag !== TAG_W'(10)) begin
      bad++; $display("FAIL bp_hold: got v=%0b %h want v=1 %h tag 10", out_valid, got, snap);
    end
    out_ready = 1'b1;
    nout = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_sign = s[idx]; in_zero = z[idx]; in_exp = e[idx]; in_sig = g[idx]; in_rm = m[idx];
        in_tag = TAG_W'(10 + idx);
      end
      #1;
      if (out_valid) begin
        got = {out_tag, out_fflags, out_result};
        exp_v = (sb.size() > 0) ? sb.pop_front() : '1;
        total++; if (got !== exp_v) begin bad++; $display("FAIL bp_drain%0d: got %h want %h", nout, got, exp_v); end
        if (first_c < 0) first_c = c;
        last_c = c;
        nout++;
      end
      if (in_valid && in_ready) begin
        sb.push_back({TAG_W'(10 + idx), model(s[idx], z[idx], e[idx], g[idx], m[idx])});
        idx++;
      end
      @(negedge clk);
    end
    total++; if (nout != 4 || last_c - first_c != 3) begin
      bad++; $display("FAIL bp_throughput: got %0d outs over %0d cycles want 4 over 4", nout, last_c - first_c + 1);
    end
  endtask

  task automatic test_reset_inflight();
    logic s, z; logic [7:0] e; logic [31:0] g; logic [2:0] m;
    logic [31:0] res; logic [4:0] ff; logic [TAG_W-1:0] otag; int lat, stale;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      gen_op(s, z, e, g, m);
      in_sign = s; in_zero = z; in_exp = e; in_sig = g; in_rm = m; in_tag = TAG_W'(40 + i);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    total++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
      bad++; $display("FAIL rst_pre: got busy=%0b v=%0b want 1 1", busy, out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_async: got v=%0b busy=%0b want 0 0", out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid || busy) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL rst_stale: got %0d cycles want 0", stale); end
    do_op(1'b0, 1'b0, 8'h97, 32'h80000080, 3'd3, TAG_W'(33), res, ff, otag, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL rst_next_latency: got %0d want 2", lat); end
    total++; if (res !== 32'h4B800001 || otag !== TAG_W'(33)) begin
      bad++; $display("FAIL rst_next_result: got %h tag %0d want 4b800001 tag 33", res, otag);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fcvt_round_stage.md
Name: fcvt_round_stage

Overview:
- Downstream rounding/packing stage for the integer-to-single conversion path (FCVT.S.W / FCVT.S.WU) in the FP execute cluster.
- Consumes the normalised, untruncated significand, biased exponent and sign produced by the int-to-float normaliser.
- Applies the RISC-V rounding mode, raises fflags and packs the IEEE-754 single result.
- Two-stage elastic valid/ready pipeline with ROB tag passthrough, feeding the FP writeback/CDB arbiter.

Parameters:
- TAG_W, 6, width of the ROB tag carried alongside each operation

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream operation valid
- in_ready  output  1  stage can accept an operation this cycle
- in_sign  input  1  result sign (1 only for negative signed source)
- in_zero  input  1  source integer was 0
- in_exp  input  8  biased exponent, 127 + index of leading one (127..158)
- in_sig  input  32  significand left-justified; bit 31 is the leading one
- in_rm  input  3  resolved rounding mode (instruction rm, or frm when DYN)
- in_tag  input  TAG_W  ROB tag
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_result  output  32  packed single-precision result
- out_fflags  output  5  {NV,DZ,OF,UF,NX}
- out_tag  output  TAG_W  ROB tag of out_result
- busy  output  1  any stage holds a valid operation

Behaviour:
- Reset (async, rst_n low): both stage valid bits cleared; out_valid=0, busy=0, out_result=0, out_fflags=0, out_tag=0. Reset mid-operation discards all in-flight operations; no partial output is emitted after release.
- Handshake: transfer on in_valid&in_ready and on out_valid&out_ready. S2 advances when S2 is empty or out_ready=1. S1 advances when S1 is empty or S1 can move into S2. in_ready = S1 empty or S1 advancing.
- Data is held stable while out_valid=1 and out_ready=0. Full throughput is one operation per cycle. Latency from input handshake to out_valid is 2 cycles with no back-pressure.
- S1 (decode/decide):
  - mant = in_sig[30:8]; G = in_sig[7]; S = |in_sig[6:0]; L = mant[0].
  - inc decision by rm:
    - 000 RNE: G&(S|L)
    - 001 RTZ: 0
    - 010 RDN: sign&(G|S)
    - 011 RUP: ~sign&(G|S)
    - 100 RMM: G
  - NX = G|S.
  - rm 101/110/111 is illegal: result = canonical NaN 0x7FC00000, fflags NV only.
  - Registers sign, exp, mant, inc, flags, tag.
- S2 (apply/pack):
  - {carry, mant'} = mant + inc (24-bit add).
  - On carry: exp' = exp+1, mant' = 0; otherwise exp' = exp.
  - result = {sign, exp', mant'}.
  - Max exponent after carry is 159, so OF and UF are never set. DZ is never set.
- Zero input: in_zero=1 gives result 0x00000000 (+0, sign ignored), fflags 0, regardless of rm, except illegal rm which still gives the NaN/NV result.
- Simultaneous input accept and output drain in the same cycle: both occur, with no bubble inserted.
- busy = S1.valid | S2.valid.

Optional Feature:
- Macro FCVT_ROUND_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 clears both stage valid bits on the next clock edge.
  - in_ready is forced to 0 during the flush cycle.
  - An operation presented with flush=1 is dropped.
  - out_valid deasserts the cycle after flush.
- When undefined: no flush port; only reset clears the pipeline.

Test Plan:
- Unsigned 0x01000001: exp 0x97, sig 0x80000080, rm RNE -> 0x4B800000, fflags NX=1 (tie, even kept). Same with rm RUP -> 0x4B800001.
- Unsigned 0xFFFFFFFF: exp 0x9E, sig 0xFFFFFFFF.
  - rm RNE -> 0x4F800000 (carry into exponent), NX=1.
  - rm RTZ -> 0x4F7FFFFF, NX=1.
- Signed -1: sign 1, exp 0x7F, sig 0x80000000, rm RDN -> 0xBF800000, fflags 0. Sign 1, exp 0x97, sig 0x80000080, rm RDN -> 0xCB800001, NX=1.
- in_zero=1 with sign 1, rm RMM -> 0x00000000, fflags 0. rm=101 -> 0x7FC00000, fflags 5'b10000.
- Back-pressure:
  - Stream 4 back-to-back ops with out_ready held low.
  - in_ready drops after 2 accepted.
  - Outputs stay stable.
  - Releasing out_ready drains all 4 in order with correct tags and one result per cycle.
- Assert rst_n low while 2 ops are in flight -> out_valid and busy go to 0 immediately. After release no stale result appears, and the next op returns after 2 cycles.
